// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN stack controller: command opcodes, stack
// instruction codes and controller FSM states.
package rpn_pkg;

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_PEEK = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam logic [1:0] SI_PUSH = 2'b00;
  localparam logic [1:0] SI_POP  = 2'b01;
  localparam logic [1:0] SI_PEEK = 2'b10;
  localparam logic [1:0] SI_IDLE = 2'b11;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_PUSH  = 4'd1;
  localparam logic [3:0] ST_POP1  = 4'd2;
  localparam logic [3:0] ST_PEEK  = 4'd3;
  localparam logic [3:0] ST_WAITP = 4'd4;
  localparam logic [3:0] ST_POP2  = 4'd5;
  localparam logic [3:0] ST_CAPB  = 4'd6;
  localparam logic [3:0] ST_PUSHR = 4'd7;
  localparam logic [3:0] ST_RESP  = 4'd8;

  function automatic logic is_binary(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational binary operator: b is the element below the top, a is the top.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_b + i_a;
      OP_SUB:  o_y = i_b - i_a;
      OP_AND:  o_y = i_b & i_a;
      OP_XOR:  o_y = i_b ^ i_a;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN command front-end: sequences push/pop/peek into a hardware stack,
// evaluates binary ops, and returns one response per command.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             sync_err,
  output logic [1:0]       stk_instr,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  input  logic             stk_empty,
  input  logic             stk_full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  logic [3:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             r_sync_err;
  logic [WIDTH-1:0] w_alu;
  logic             w_reject;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op (r_op),
    .i_b  (r_b),
    .i_a  (r_a),
    .o_y  (w_alu)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign sync_err  = r_sync_err;

  always_comb begin
    stk_instr = SI_IDLE;
    stk_wdata = '0;
    case (r_state)
      ST_PUSH: begin
        stk_instr = SI_PUSH;
        stk_wdata = r_imm;
      end
      ST_POP1, ST_POP2: stk_instr = SI_POP;
      ST_PEEK:          stk_instr = SI_PEEK;
      ST_PUSHR: begin
        stk_instr = SI_PUSH;
        stk_wdata = w_alu;
      end
      default: stk_instr = SI_IDLE;
    endcase
  end

  // Occupancy-based rejection of the command being offered
  always_comb begin
    w_reject = 1'b1;
    case (cmd_op)
      OP_PUSH:         w_reject = (r_count == FULL_CNT);
      OP_POP, OP_PEEK: w_reject = (r_count == '0);
      default:         w_reject = is_binary(cmd_op) ? (r_count < TWO_CNT) : 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_op        <= OP_PUSH;
      r_imm       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sync_err <= r_sync_err | ((r_count == '0) != stk_empty)
                                   | ((r_count == FULL_CNT) != stk_full);
          if (cmd_valid) begin
            r_op  <= cmd_op;
            r_imm <= cmd_imm;
            if (w_reject) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              case (cmd_op)
                OP_PUSH: r_state <= ST_PUSH;
                OP_PEEK: r_state <= ST_PEEK;
                default: r_state <= ST_POP1;
              endcase
            end
          end
        end
        ST_PUSH: begin
          r_count     <= r_count + ONE_CNT;
          r_rsp_data  <= r_imm;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_POP1: begin
          r_count <= r_count - ONE_CNT;
          r_state <= (r_op == OP_POP) ? ST_WAITP : ST_POP2;
        end
        ST_PEEK: r_state <= ST_WAITP;
        ST_WAITP: begin
          r_rsp_data  <= stk_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        // Read data lags the pop by a cycle: top arrives here, second in CAPB
        ST_POP2: begin
          r_count <= r_count - ONE_CNT;
          r_a     <= stk_rdata;
          r_state <= ST_CAPB;
        end
        ST_CAPB: begin
          r_b     <= stk_rdata;
          r_state <= ST_PUSHR;
        end
        ST_PUSHR: begin
          r_count     <= r_count + ONE_CNT;
          r_rsp_data  <= w_alu;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
